// File: rtl/throughout_chk_pkg.sv
// throughout_chk_pkg
// Shared types for the throughout_chk protocol checker.
//   fail_code_e : reason reported alongside a fail pulse
//   chk_state_e : per-channel checker FSM state
package throughout_chk_pkg;

  typedef enum logic [1:0] {
    FC_NONE   = 2'd0,
    FC_NO_B   = 2'd1,
    FC_A_DROP = 2'd2,
    FC_C_DROP = 2'd3
  } fail_code_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chk_state_e;

endpackage

// File: rtl/throughout_chk_lane.sv
// throughout_chk_lane
// One channel of the checker for rose(a) |-> a throughout (rose(b) ##1 c[*RUN]).
// Optional saturating pass/fail counters when THROUGHOUT_CHK_CNT_EN is defined.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en_i              enable; low aborts the run without a pulse
//   run_len_i         RUN length, captured at the trigger
//   a_i, b_i, c_i     protocol signals of this channel
//   busy_o            FSM is in RUN
//   pass_o, fail_o    registered 1-cycle result pulses
//   fail_code_o       reason, valid while fail_o is high
//   pass_cnt_o, fail_cnt_o  saturating counts (macro only)
module throughout_chk_lane
  import throughout_chk_pkg::*;
#(
  parameter int LEN_W = 4
`ifdef THROUGHOUT_CHK_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [LEN_W-1:0] run_len_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             c_i,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic [1:0]       fail_code_o
`ifdef THROUGHOUT_CHK_CNT_EN
  , output logic [CNT_W-1:0] pass_cnt_o
  , output logic [CNT_W-1:0] fail_cnt_o
`endif
);

  chk_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             a_q, b_q;
  logic             rose_a, rose_b;
  logic             pass_d, fail_d;
  fail_code_e       code_d, code_q;

  assign rose_a = a_i & ~a_q;
  assign rose_b = b_i & ~b_q;

  // Edge-detect history keeps tracking the inputs even while disabled, so
  // re-enabling does not see a stale level as a fresh rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_o  <= 1'b0;
      fail_o  <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      a_q     <= a_i;
      b_q     <= b_i;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_o  <= pass_d;
      fail_o  <= fail_d;
      code_q  <= code_d;
    end
  end

  // In RUN the a-drop check wins over the c-drop check; the final pass needs
  // c high on the last counted edge as well.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    code_d  = FC_NONE;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rose_a) begin
            if (!rose_b) begin
              fail_d = 1'b1;
              code_d = FC_NO_B;
            end else if (run_len_i == '0) begin
              pass_d = 1'b1;
            end else begin
              cnt_d   = run_len_i;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (!a_i) begin
            fail_d  = 1'b1;
            code_d  = FC_A_DROP;
            state_d = IDLE;
          end else if (!c_i) begin
            fail_d  = 1'b1;
            code_d  = FC_C_DROP;
            state_d = IDLE;
          end else if (cnt_q == LEN_W'(1)) begin
            pass_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q == RUN);
  assign fail_code_o = code_q;

`ifdef THROUGHOUT_CHK_CNT_EN
  // Counters follow the registered pulses, so they settle one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_o <= '0;
      fail_cnt_o <= '0;
    end else begin
      if (pass_o && (pass_cnt_o != '1)) pass_cnt_o <= pass_cnt_o + 1'b1;
      if (fail_o && (fail_cnt_o != '1)) fail_cnt_o <= fail_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/throughout_chk.sv
// throughout_chk
// Multi-channel checker for rose(a) |-> a throughout (rose(b) ##1 c[*RUN]).
// NCH independent lanes share en_i and run_len_i.
// Optional feature macro: THROUGHOUT_CHK_CNT_EN adds per-channel saturating
// pass/fail counters (pass_cnt_o, fail_cnt_o, parameter CNT_W).
// Ports:
//   clk, rst_n     clock, async active-low reset
//   en_i           enable for all channels
//   run_len_i      RUN length, captured per channel at its trigger
//   a_i, b_i, c_i  per-channel protocol signals
//   busy_o         per-channel RUN indication
//   pass_o, fail_o per-channel 1-cycle result pulses
//   fail_code_o    channel i reason at [2i+:2]
//   pass_cnt_o, fail_cnt_o  channel i count at [CNT_W*i+:CNT_W] (macro only)
module throughout_chk
  import throughout_chk_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int LEN_W = 4
`ifdef THROUGHOUT_CHK_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [LEN_W-1:0]   run_len_i,
  input  logic [NCH-1:0]     a_i,
  input  logic [NCH-1:0]     b_i,
  input  logic [NCH-1:0]     c_i,
  output logic [NCH-1:0]     busy_o,
  output logic [NCH-1:0]     pass_o,
  output logic [NCH-1:0]     fail_o,
  output logic [2*NCH-1:0]   fail_code_o
`ifdef THROUGHOUT_CHK_CNT_EN
  , output logic [CNT_W*NCH-1:0] pass_cnt_o
  , output logic [CNT_W*NCH-1:0] fail_cnt_o
`endif
);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    throughout_chk_lane #(
      .LEN_W (LEN_W)
`ifdef THROUGHOUT_CHK_CNT_EN
      , .CNT_W (CNT_W)
`endif
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (en_i),
      .run_len_i   (run_len_i),
      .a_i         (a_i[i]),
      .b_i         (b_i[i]),
      .c_i         (c_i[i]),
      .busy_o      (busy_o[i]),
      .pass_o      (pass_o[i]),
      .fail_o      (fail_o[i]),
      .fail_code_o (fail_code_o[2*i +: 2])
`ifdef THROUGHOUT_CHK_CNT_EN
      , .pass_cnt_o (pass_cnt_o[CNT_W*i +: CNT_W])
      , .fail_cnt_o (fail_cnt_o[CNT_W*i +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_throughout_chk.sv
// tb_throughout_chk
// Directed self-checking bench for throughout_chk (NCH=4, LEN_W=4).
// Expected outputs for each step are queued when the step is driven and
// popped after the following clock edge.
module tb_throughout_chk;

  localparam int NCH   = 4;
  localparam int LEN_W = 4;
`ifdef THROUGHOUT_CHK_CNT_EN
  localparam int CNT_W = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [LEN_W-1:0] run_len;
  logic [NCH-1:0]   a, b, c;
  logic [NCH-1:0]   busy, pass, fail;
  logic [2*NCH-1:0] fail_code;
`ifdef THROUGHOUT_CHK_CNT_EN
  logic [CNT_W*NCH-1:0] pass_cnt, fail_cnt;
`endif

  typedef struct packed {
    logic [NCH-1:0]   pass;
    logic [NCH-1:0]   fail;
    logic [NCH-1:0]   busy;
    logic [2*NCH-1:0] code;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  throughout_chk #(
    .NCH   (NCH),
    .LEN_W (LEN_W)
`ifdef THROUGHOUT_CHK_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .run_len_i   (run_len),
    .a_i         (a),
    .b_i         (b),
    .c_i         (c),
    .busy_o      (busy),
    .pass_o      (pass),
    .fail_o      (fail),
    .fail_code_o (fail_code)
`ifdef THROUGHOUT_CHK_CNT_EN
    , .pass_cnt_o (pass_cnt)
    , .fail_cnt_o (fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      compareVal({tag, ".pass"}, 8'(pass), 8'(e.pass));
      compareVal({tag, ".fail"}, 8'(fail), 8'(e.fail));
      compareVal({tag, ".busy"}, 8'(busy), 8'(e.busy));
      compareVal({tag, ".code"}, 8'(fail_code), 8'(e.code));
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge
  // that samples them, then check once that edge has passed.
  task automatic applyStimulus(input string tag, input logic en_v, input logic [LEN_W-1:0] len_v,
                               input logic [NCH-1:0] a_v, b_v, c_v,
                               input logic [NCH-1:0] ep, ef, eb, input logic [2*NCH-1:0] ec);
    exp_t e;
    en      = en_v;
    run_len = len_v;
    a       = a_v;
    b       = b_v;
    c       = c_v;
    e.pass  = ep;
    e.fail  = ef;
    e.busy  = eb;
    e.code  = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    run_len = '0;
    a = '0; b = '0; c = '0;
    #2;
    compareVal("reset.pass", 8'(pass), 8'h00);
    compareVal("reset.fail", 8'(fail), 8'h00);
    compareVal("reset.busy", 8'(busy), 8'h00);
    compareVal("reset.code", 8'(fail_code), 8'h00);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus("idle", 1, 2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // T1: pass with RUN=2
    applyStimulus("t1.trig", 1, 2, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 8'h00);
    applyStimulus("t1.c1",   1, 2, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 8'h00);
    applyStimulus("t1.c2",   1, 2, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    applyStimulus("t1.post", 1, 2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    applyStimulus("t1.aoff", 1, 2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // T2: a drops mid-run, c high in the same cycle
    applyStimulus("t2.trig", 1, 2, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 8'h00);
    applyStimulus("t2.c1",   1, 2, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 8'h00);
    applyStimulus("t2.drop", 1, 2, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 8'h02);
    applyStimulus("t2.post", 1, 2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // T3: c drops with RUN=3
    applyStimulus("t3.trig", 1, 3, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 8'h00);
    applyStimulus("t3.c1",   1, 3, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 8'h00);
    applyStimulus("t3.c2",   1, 3, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 8'h00);
    applyStimulus("t3.drop", 1, 3, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 8'h03);
    applyStimulus("t3.post", 1, 3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // T4: a rises without b
    applyStimulus("t4.trig", 1, 2, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 8'h01);
    applyStimulus("t4.hold", 1, 2, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 8'h00);
    applyStimulus("t4.post", 1, 2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // T5: RUN=0 passes immediately
    applyStimulus("t5.run0", 1, 0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 8'h00);
    applyStimulus("t5.r0off", 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // T5: RUN=15, run_len changed mid-run must not shorten it
    applyStimulus("t5.r15trig", 1, 15, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 8'h00);
    for (int i = 0; i < 14; i++)
      applyStimulus("t5.r15c", 1, 1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 8'h00);
    applyStimulus("t5.r15last", 1, 1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
    applyStimulus("t5.r15off", 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // T5: disable mid-run aborts silently, no retrigger while a stays high
    applyStimulus("t5.entrig", 1, 2, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 8'h00);
    applyStimulus("t5.enoff",  0, 2, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 8'h00);
    applyStimulus("t5.enback", 1, 2, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    applyStimulus("t5.enpost", 1, 2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // T6: ch0 pass, ch1 c-drop together; ch2 no-b at the trigger
    applyStimulus("t6.trig", 1, 2, 4'h7, 4'h3, 4'h0, 4'h0, 4'h4, 4'h3, 8'h10);
    applyStimulus("t6.c1",   1, 2, 4'h3, 4'h0, 4'h3, 4'h0, 4'h0, 4'h3, 8'h00);
    applyStimulus("t6.c2",   1, 2, 4'h3, 4'h0, 4'h1, 4'h1, 4'h2, 4'h0, 8'h0C);
    applyStimulus("t6.post", 1, 2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    // Five more ch0 passes to push the 2-bit counter into saturation
    for (int i = 0; i < 5; i++) begin
      applyStimulus("t6.rep", 1, 0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 8'h00);
      applyStimulus("t6.repoff", 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    end
`ifdef THROUGHOUT_CHK_CNT_EN
    compareVal("cnt.pass0", 8'(pass_cnt[1:0]), 8'd3);
    compareVal("cnt.pass1", 8'(pass_cnt[3:2]), 8'd0);
    compareVal("cnt.fail0", 8'(fail_cnt[1:0]), 8'd3);
    compareVal("cnt.fail1", 8'(fail_cnt[3:2]), 8'd1);
    compareVal("cnt.fail2", 8'(fail_cnt[5:4]), 8'd1);
`endif

    // Async reset mid-run clears everything without a pulse
    applyStimulus("rst.trig", 1, 3, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 8'h00);
    a = 4'h1; c = 4'h1; b = 4'h0;
    #1;
    rst_n = 1'b0;
    #1;
    compareVal("rst.busy", 8'(busy), 8'h00);
    compareVal("rst.pass", 8'(pass), 8'h00);
    compareVal("rst.fail", 8'(fail), 8'h00);
    compareVal("rst.code", 8'(fail_code), 8'h00);
`ifdef THROUGHOUT_CHK_CNT_EN
    compareVal("rst.pcnt", 8'(pass_cnt), 8'h00);
`endif
    a = '0; c = '0;
    @(posedge clk);
    #1;
    compareVal("rst.hold", 8'(pass | fail | busy), 8'h00);
    rst_n = 1'b1;

    // a=1 on the first edge after reset counts as a rise
    applyStimulus("rst.rise", 1, 0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 8'h00);
    applyStimulus("rst.off",  1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
